// File: rtl/spring_launcher_pkg.sv
// Shared spring/launcher defines: plunger geometry, default launch constants and launcher FSM states.
package spring_launcher_pkg;

  localparam int SCREEN_MAIN_SPRING_TOP_LEFT_Y = 420;

  localparam int DEF_LAUNCH_BASE      = 64;
  localparam int DEF_LAUNCH_GAIN      = 16;
  localparam int DEF_LAUNCH_SPEED_MAX = 1024;
  localparam int COOLDOWN_FRAMES      = 30;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHARGING,
    ST_RELEASING,
    ST_LAUNCH,
    ST_COOLDOWN
  } launch_state_e;

endpackage

// File: rtl/spring_launcher_launch_speed_calc.sv
// Combinational launch speed: -min(BASE + depth*GAIN, MAX), 32-bit signed, negative = up.
module launch_speed_calc #(
  parameter int LAUNCH_BASE      = 64,
  parameter int LAUNCH_GAIN      = 16,
  parameter int LAUNCH_SPEED_MAX = 1024
) (
  input  logic        [10:0] depth_i,
  output logic signed [31:0] speed_o
);

  localparam logic signed [31:0] BASE_S = 32'(LAUNCH_BASE);
  localparam logic signed [31:0] GAIN_S = 32'(LAUNCH_GAIN);
  localparam logic signed [31:0] MAX_S  = 32'(LAUNCH_SPEED_MAX);

  logic signed [31:0] depth_s;
  logic signed [31:0] mag;

  assign depth_s = $signed({21'd0, depth_i});
  assign mag     = BASE_S + depth_s * GAIN_S;
  // Saturate on the magnitude, then negate so the ball moves up.
  assign speed_o = (mag > MAX_S) ? -MAX_S : -mag;

endmodule

// File: rtl/spring_launcher.sv
// Turns a pull-and-release plunger stroke into a one-clk launch strobe with a depth-scaled upward speed.
// Optional: define SPRING_LAUNCH_MIN_DEPTH_EN to treat hits shallower than MIN_DEPTH as dry fires.
module spring_launcher
  import spring_launcher_pkg::*;
#(
  parameter int REST_Y           = SCREEN_MAIN_SPRING_TOP_LEFT_Y,
  parameter int LAUNCH_BASE      = DEF_LAUNCH_BASE,
  parameter int LAUNCH_GAIN      = DEF_LAUNCH_GAIN,
  parameter int LAUNCH_SPEED_MAX = DEF_LAUNCH_SPEED_MAX,
  parameter int COOLDOWN_FRAMES  = spring_launcher_pkg::COOLDOWN_FRAMES
`ifdef SPRING_LAUNCH_MIN_DEPTH_EN
  ,
  parameter int MIN_DEPTH        = 4
`endif
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic signed [10:0] springTopLeftY,
  input  logic signed [31:0] springSpeedY,
  input  logic               collisionSpringBall,
  input  logic               ballInLane,
  output logic               launchPulse,
  output logic signed [31:0] launchSpeedY,
  output logic        [10:0] compressionDepth,
  output logic               busy
);

  launch_state_e      state_q, state_d;
  logic        [10:0] depth_q, depth_d;
  logic               hit_q, hit_d;
  logic   [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [31:0] speed_q, speed_d;

  logic signed [12:0] diff;
  logic        [10:0] depth_now;
  logic signed [31:0] calc_speed;
  logic               hit_now;
  logic               depth_ok;

  assign diff = 13'(springTopLeftY) - 13'(REST_Y);

  always_comb begin
    depth_now = diff[10:0];
    if (diff < 0) begin
      depth_now = '0;
    end else if (diff > 13'sd2047) begin
      depth_now = 11'd2047;
    end
  end

`ifdef SPRING_LAUNCH_MIN_DEPTH_EN
  assign depth_ok = (depth_q >= 11'(MIN_DEPTH));
`else
  assign depth_ok = 1'b1;
`endif

  launch_speed_calc #(
    .LAUNCH_BASE      (LAUNCH_BASE),
    .LAUNCH_GAIN      (LAUNCH_GAIN),
    .LAUNCH_SPEED_MAX (LAUNCH_SPEED_MAX)
  ) u_calc (
    .depth_i (depth_q),
    .speed_o (calc_speed)
  );

  // A collision on the tick itself counts toward that tick's decision.
  assign hit_now = hit_q | collisionSpringBall;

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    hit_d   = hit_q;
    cnt_d   = cnt_q;
    speed_d = speed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (startOfFrame && springSpeedY > 0) begin
          state_d = ST_CHARGING;
          depth_d = '0;
          hit_d   = 1'b0;
        end
      end
      ST_CHARGING: begin
        if (startOfFrame) begin
          if (depth_now > depth_q) depth_d = depth_now;
          if (springSpeedY < 0) state_d = ST_RELEASING;
        end
      end
      ST_RELEASING: begin
        if (collisionSpringBall) hit_d = 1'b1;
        if (startOfFrame) begin
          if (hit_now && ballInLane) begin
            if (depth_ok) begin
              state_d = ST_LAUNCH;
              speed_d = calc_speed;
            end else begin
              state_d = ST_IDLE;
              depth_d = '0;
              hit_d   = 1'b0;
            end
          end else if (springSpeedY > 0) begin
            state_d = ST_CHARGING;
          end else if (diff <= 0) begin
            state_d = ST_IDLE;
            depth_d = '0;
            hit_d   = 1'b0;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_COOLDOWN;
        hit_d   = 1'b0;
        cnt_d   = CNT_W'(COOLDOWN_FRAMES);
      end
      ST_COOLDOWN: begin
        if (startOfFrame) begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      depth_q <= '0;
      hit_q   <= 1'b0;
      cnt_q   <= '0;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      hit_q   <= hit_d;
      cnt_q   <= cnt_d;
      speed_q <= speed_d;
    end
  end

  assign launchPulse      = (state_q == ST_LAUNCH);
  assign launchSpeedY     = speed_q;
  assign compressionDepth = depth_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spring_launcher.sv
// Directed and randomized plunger strokes checked against a stroke-level reference model.
module tb_spring_launcher;

  localparam int REST = 420;
  localparam int BASE = 64;
  localparam int GAIN = 16;
  localparam int SMAX = 1024;
  localparam int COOL = 30;
  localparam int MIND = 4;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic signed [10:0] springTopLeftY;
  logic signed [31:0] springSpeedY;
  logic               collisionSpringBall;
  logic               ballInLane;
  logic               launchPulse;
  logic signed [31:0] launchSpeedY;
  logic        [10:0] compressionDepth;
  logic               busy;

  int errors = 0;
  int checks = 0;

  // Reference model: stroke in progress, released, latched hit, cooldown frames left.
  bit m_stroke, m_released, m_hit, m_cooling, m_pulse;
  int m_cool_left, m_maxd, m_speed;

  spring_launcher dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .springTopLeftY      (springTopLeftY),
    .springSpeedY        (springSpeedY),
    .collisionSpringBall (collisionSpringBall),
    .ballInLane          (ballInLane),
    .launchPulse         (launchPulse),
    .launchSpeedY        (launchSpeedY),
    .compressionDepth    (compressionDepth),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stroke = 0; m_released = 0; m_hit = 0; m_cooling = 0; m_pulse = 0;
    m_cool_left = 0; m_maxd = 0; m_speed = 0;
  endtask

  function automatic int depth_of(input int y);
    int d;
    d = y - REST;
    if (d < 0) d = 0;
    if (d > 2047) d = 2047;
    return d;
  endfunction

  task automatic model_tick(input int y, input int spd, input bit coll, input bit lane);
    int d, mag;
    bit deep_enough;
    m_pulse = 0;
    d = depth_of(y);
    if (m_cooling) begin
      if (m_cool_left <= 1) m_cooling = 0;
      else m_cool_left--;
    end else if (!m_stroke) begin
      if (spd > 0) begin
        m_stroke = 1; m_released = 0; m_maxd = 0; m_hit = 0;
      end
    end else if (!m_released) begin
      if (d > m_maxd) m_maxd = d;
      if (spd < 0) m_released = 1;
    end else begin
      if (coll) m_hit = 1;
`ifdef SPRING_LAUNCH_MIN_DEPTH_EN
      deep_enough = (m_maxd >= MIND);
`else
      deep_enough = 1;
`endif
      if (m_hit && lane) begin
        if (deep_enough) begin
          mag = BASE + m_maxd * GAIN;
          if (mag > SMAX) mag = SMAX;
          m_speed = -mag;
          m_pulse = 1;
          m_stroke = 0; m_hit = 0;
          m_cooling = 1; m_cool_left = COOL;
        end else begin
          m_stroke = 0; m_hit = 0; m_maxd = 0;
        end
      end else if (spd > 0) begin
        m_released = 0;
      end else if (y <= REST) begin
        m_stroke = 0; m_hit = 0; m_maxd = 0;
      end
    end
  endtask

  task automatic frame(input string tag, input int y, input int spd, input bit coll, input bit lane);
    @(negedge clk);
    springTopLeftY = 11'(y);
    springSpeedY = spd;
    collisionSpringBall = coll;
    ballInLane = lane;
    startOfFrame = 1'b1;
    model_tick(y, spd, coll, lane);
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 32'(launchPulse), 32'(m_pulse));
    chk({tag, ".speed"}, launchSpeedY, m_speed);
    chk({tag, ".depth"}, 32'(compressionDepth), m_maxd);
    chk({tag, ".busy"}, 32'(busy), 32'(m_stroke | m_cooling | m_pulse));
    @(negedge clk);
    startOfFrame = 1'b0;
    collisionSpringBall = 1'b0;
    if (m_pulse) begin
      @(posedge clk); #1;
      chk({tag, ".pulse_one_clk"}, 32'(launchPulse), 0);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic coll_between();
    @(negedge clk);
    collisionSpringBall = 1'b1;
    if (m_stroke && m_released && !m_cooling) m_hit = 1;
    @(negedge clk);
    collisionSpringBall = 1'b0;
  endtask

  task automatic rest_frames(input string tag, input int n, input bit coll);
    for (int i = 0; i < n; i++) frame(tag, REST, 0, coll, 1'b1);
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 1'b0;
    springTopLeftY = 11'(REST);
    springSpeedY = 0;
    collisionSpringBall = 1'b0;
    ballInLane = 1'b0;
    model_reset();
    #1;
    chk("reset.pulse", 32'(launchPulse), 0);
    chk("reset.speed", launchSpeedY, 0);
    chk("reset.depth", 32'(compressionDepth), 0);
    chk("reset.busy", 32'(busy), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) resetN = 1'b1;
    repeat (2) @(posedge clk);

    // Pull to 40 px, release, hit on the tick: -704, then cooldown with collisions.
    frame("a.idle", REST, 0, 0, 1);
    frame("a.ch0", 430, 5, 0, 1);
    frame("a.ch1", 440, 5, 0, 1);
    frame("a.ch2", 450, 5, 0, 1);
    frame("a.ch3", 460, 5, 0, 1);
    frame("a.hold", 460, 0, 0, 1);
    frame("a.rel", 440, -8, 0, 1);
    frame("a.hit", 430, -8, 1, 1);
    rest_frames("a.cool", 29, 1);
    chk("a.busy_before_end", 32'(busy), 1);
    frame("a.cool_end", REST, 0, 1, 1);
    chk("a.busy_after", 32'(busy), 0);

    // 100 px saturates; re-press on the same tick as a between-frame hit: hit wins.
    frame("b.ch0", 430, 5, 0, 1);
    frame("b.ch1", 520, 5, 0, 1);
    frame("b.rel", 500, -8, 0, 1);
    coll_between();
    frame("b.hit", 510, 5, 0, 1);
    rest_frames("b.cool", 30, 0);

    // Release without collision: dry fire back to rest.
    frame("c.ch0", 430, 5, 0, 1);
    frame("c.ch1", 450, 5, 0, 1);
    frame("c.rel", 435, -8, 0, 1);
    frame("c.rest", REST, -8, 0, 1);
    frame("c.idle", REST, 0, 0, 1);

    // Charge 20, release, re-press to 30, release, hit with lane blocked first.
    frame("d.ch0", 425, 5, 0, 1);
    frame("d.ch1", 440, 5, 0, 1);
    frame("d.rel", 430, -8, 0, 1);
    frame("d.repress", 445, 5, 0, 1);
    frame("d.ch2", 450, 5, 0, 1);
    frame("d.rel2", 440, -8, 0, 1);
    frame("d.nolane", 435, -8, 1, 0);
    frame("d.hit", 430, -8, 0, 1);
    rest_frames("d.cool", 30, 0);

    // Depth 3 with a hit: -112, or a dry fire when the minimum depth is enforced.
    frame("e.ch0", 421, 5, 0, 1);
    frame("e.ch1", 423, 5, 0, 1);
    frame("e.rel", 422, -8, 0, 1);
    frame("e.hit", 421, -8, 1, 1);
    rest_frames("e.cool", 30, 0);

    // Reset mid-charge clears everything at once.
    frame("f.ch0", 430, 5, 0, 1);
    frame("f.ch1", 470, 5, 0, 1);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    model_reset();
    chk("f.rst_pulse", 32'(launchPulse), 0);
    chk("f.rst_speed", launchSpeedY, 0);
    chk("f.rst_depth", 32'(compressionDepth), 0);
    chk("f.rst_busy", 32'(busy), 0);
    @(negedge clk) resetN = 1'b1;
    frame("f.after", 470, -8, 1, 1);

    // Randomized strokes.
    for (int s = 0; s < 20; s++) begin
      int dep, k, j, hitf;
      bit between;
      dep = $urandom_range(0, 120);
      k = $urandom_range(1, 3);
      j = $urandom_range(2, 4);
      hitf = $urandom_range(1, j + 1);
      between = ($urandom_range(0, 1) == 1);
      frame("r.start", REST, 6, 0, 1);
      for (int i = 1; i <= k; i++) frame("r.charge", REST + dep * i / k, 6, 0, 1);
      for (int i = 1; i <= j; i++) begin
        bit lane;
        lane = ($urandom_range(0, 3) != 0);
        if (i == hitf && between) coll_between();
        frame("r.release", REST + dep * (j - i) / j, -6, (i == hitf) && !between, lane);
      end
      rest_frames("r.drain", 31, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spring_launcher.md
# spring_launcher

Consumes the spring plunger's per-frame position and velocity and turns a completed pull-and-release stroke into a single ball launch impulse. Sits between the spring controller, the pixel-level collision logic and the ball controller. Tracks the compression depth while the plunger is charging. When the released plunger strikes the ball, it issues a one-clock launch strobe carrying an upward fixed-point speed proportional to that depth.

## Interface
Parameters:
- REST_Y, 420, plunger rest top-left Y in pixels (package default SCREEN_MAIN_SPRING_TOP_LEFT_Y)
- LAUNCH_BASE, 64, fixed-point speed magnitude added to every launch
- LAUNCH_GAIN, 16, fixed-point speed magnitude per pixel of depth
- LAUNCH_SPEED_MAX, 1024, saturation limit on launch speed magnitude
- COOLDOWN_FRAMES, 30, frames ignored after a launch
- MIN_DEPTH, 4, minimum depth in pixels for a valid launch (used only with the macro)

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-clk frame tick
- springTopLeftY  in  11 signed  plunger top-left Y in pixels
- springSpeedY  in  32 signed  plunger speed, fixed point, positive = down
- collisionSpringBall  in  1  pixel-level overlap strobe, any cycle
- ballInLane  in  1  ball resting in the launch lane
- launchPulse  out  1  one-clk launch strobe
- launchSpeedY  out  32 signed  launch speed, negative = up; held until the next launch
- compressionDepth  out  11 unsigned  maximum depth of the current stroke, for the HUD
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CHARGING, RELEASING, LAUNCH, COOLDOWN.
- Depth is computed each frame as springTopLeftY − REST_Y, clamped to 0 and to 11 bits unsigned.
- State transitions occur only on startOfFrame, except LAUNCH, which lasts exactly one clk.
- IDLE → CHARGING when springSpeedY > 0. compressionDepth clears to 0 on this entry.
- CHARGING:
  - compressionDepth ← max(compressionDepth, depth) on every frame.
  - → RELEASING when springSpeedY < 0.
  - Stays in CHARGING while speed = 0 with the plunger held low.
- RELEASING:
  - A sticky hitLatch sets on any clk where collisionSpringBall = 1.
  - At a frame tick, if hitLatch and ballInLane → LAUNCH.
  - Otherwise, if springSpeedY > 0 (re-press) → CHARGING, with compressionDepth retained.
  - Otherwise, if springTopLeftY ≤ REST_Y → IDLE (dry fire: no launch, depth cleared).
- LAUNCH:
  - launchPulse = 1 for one clk.
  - launchSpeedY ← −min(LAUNCH_BASE + compressionDepth·LAUNCH_GAIN, LAUNCH_SPEED_MAX).
  - hitLatch clears; the cooldown counter loads COOLDOWN_FRAMES; → COOLDOWN.
- COOLDOWN:
  - The counter decrements on each startOfFrame; → IDLE when it reaches 0.
  - Inputs are ignored and hitLatch stays clear.
- Arithmetic: the product is formed in 32-bit signed; the saturation compare is done before negation. No overflow is possible for depth ≤ 2047 at the default gain.
- Simultaneous events:
  - A collision on the same clk as startOfFrame counts toward hitLatch for that tick.
  - Re-press and hit on the same tick: hit wins.

## Timing
- Reset values: state IDLE; launchPulse 0; launchSpeedY 0; compressionDepth 0; busy 0; hitLatch 0; counter 0.
- launchPulse asserts on the clk after the qualifying startOfFrame (1-clk latency). launchSpeedY updates on the same clk and is valid while the pulse is high.
- Exactly one launchPulse per stroke. None is issued in COOLDOWN, even if a collision occurs.
- Assertion of resetN mid-stroke returns all registers to their reset values immediately; no launch occurs.
- COOLDOWN_FRAMES = 0: COOLDOWN exits to IDLE on the first frame tick.

## Configuration
- SPRING_LAUNCH_MIN_DEPTH_EN:
  - Defined: a qualifying hit with compressionDepth < MIN_DEPTH behaves as a dry fire (→ IDLE, no pulse).
  - Undefined: any depth, including 0, launches at ≥ LAUNCH_BASE.

## Structure
- The state enum, the default launch constants and COOLDOWN_FRAMES go in the shared defines package, next to the spring constants.
- One sub-module, launch_speed_calc: a combinational multiply-add-saturate-negate taking depth and producing the speed.

## Test plan
- Depth 0 → 40 px, release, collision with ballInLane=1 → single launchPulse with launchSpeedY = −704.
- Depth 100 px, hit → launchSpeedY saturates at −1024.
- Release with no collision → plunger reaches REST_Y → IDLE, no pulse, compressionDepth = 0.
- Collision during COOLDOWN frames 1–29 → no pulse; busy drops to 0 after 30 frames.
- Charge to 20 px, release, re-press to 30 px, release, hit → −544 (depth 30 retained as max).
- With SPRING_LAUNCH_MIN_DEPTH_EN, depth 3 plus hit → no pulse; without the macro → −112. Assert resetN mid-CHARGING → all outputs 0.
